// File: rtl/benes_stage_pipe_pkg.sv
// Shared constants and types for the Benes stage pipeline.
package usr_fun;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_SIZE       = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_SWITCH_NUM = DEF_SIZE / 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] port_vec_t [0:DEF_SIZE-1];

endpackage

// File: rtl/benes_stage_pipe_stage_permute.sv
// Combinational row of SIZE/2 2x2 switches; cfg bit i crosses pair (2i, 2i+1).
module stage_permute #(
  parameter int DATA_WIDTH = usr_fun::DEF_DATA_WIDTH,
  parameter int SIZE       = usr_fun::DEF_SIZE
) (
  input  logic [SIZE/2-1:0]     cfg,
  input  logic [DATA_WIDTH-1:0] in_data  [0:SIZE-1],
  output logic [DATA_WIDTH-1:0] out_data [0:SIZE-1]
);

  genvar gi;
  generate
    for (gi = 0; gi < SIZE / 2; gi++) begin : g_sw
      assign out_data[2*gi]   = cfg[gi] ? in_data[2*gi+1] : in_data[2*gi];
      assign out_data[2*gi+1] = cfg[gi] ? in_data[2*gi]   : in_data[2*gi+1];
    end
  endgenerate

endmodule

// File: rtl/benes_stage_pipe.sv
// One pipelined Benes stage: double-buffered switch config, permute-then-store,
// two-entry skid buffer so in_ready is a flop with no path from out_ready.
module benes_stage_pipe
  import usr_fun::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int SIZE       = DEF_SIZE,
  parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int SWITCH_NUM = SIZE / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [SWITCH_NUM-1:0] cfg_bits,
  input  logic                  cfg_commit,
  input  logic                  bypass,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [0:SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:SIZE-1],
  output logic [SWITCH_NUM-1:0] active_cfg,
  output logic                  cfg_pending,
  output logic [CNT_WIDTH-1:0]  vec_count
);

  state_t                  state_reg, state_next;
  logic                    in_ready_reg;
  logic [SWITCH_NUM-1:0]   shadow_reg, shadow_next;
  logic [SWITCH_NUM-1:0]   active_reg, active_next;
  logic [SWITCH_NUM-1:0]   eff_cfg;
  logic                    cfg_pending_reg;
  logic [CNT_WIDTH-1:0]    vec_count_reg;
  logic [DATA_WIDTH-1:0]   routed   [0:SIZE-1];
  logic [DATA_WIDTH-1:0]   main_reg [0:SIZE-1];
  logic [DATA_WIDTH-1:0]   skid_reg [0:SIZE-1];
  logic                    accept, deliver;
  logic                    load_main, load_skid, skid_to_main;

  assign accept  = in_valid && in_ready_reg;
  assign deliver = out_valid && out_ready;

  // The config used by a vector is the one active before this edge's commit.
  assign eff_cfg = bypass ? '0 : active_reg;

  stage_permute #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE)
  ) u_permute (
    .cfg      (eff_cfg),
    .in_data  (in_data),
    .out_data (routed)
  );

  // Write-through: a simultaneous load and commit lands cfg_bits in both.
  always_comb begin
    shadow_next = cfg_valid  ? cfg_bits    : shadow_reg;
    active_next = cfg_commit ? shadow_next : active_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg      <= '0;
      active_reg      <= '0;
      cfg_pending_reg <= 1'b0;
    end else begin
      shadow_reg      <= shadow_next;
      active_reg      <= active_next;
      cfg_pending_reg <= (shadow_next != active_next);
    end
  end

  always_comb begin
    state_next   = state_reg;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !out_ready) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (accept) begin
          load_main = 1'b1;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_next   = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // in_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b0;
      vec_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
      if (deliver) begin
        vec_count_reg <= vec_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        main_reg[i] <= '0;
        skid_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (load_main) begin
          main_reg[i] <= routed[i];
        end else if (skid_to_main) begin
          main_reg[i] <= skid_reg[i];
        end
        if (load_skid) begin
          skid_reg[i] <= routed[i];
        end
      end
    end
  end

  assign out_valid   = (state_reg != ST_EMPTY);
  assign in_ready    = in_ready_reg;
  assign out_data    = main_reg;
  assign active_cfg  = active_reg;
  assign cfg_pending = cfg_pending_reg;
  assign vec_count   = vec_count_reg;

endmodule

// File: tb/tb_benes_stage_pipe.sv
// Self-checking bench: directed steps then random traffic against a queue model.
module tb_benes_stage_pipe;

  localparam int DW = 4;
  localparam int SZ = 32;
  localparam int SN = 16;

  typedef logic [DW-1:0] vec_t [0:SZ-1];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid, cfg_commit, bypass, in_valid, out_ready;
  logic [SN-1:0] cfg_bits;
  vec_t          in_data;
  logic          in_ready, out_valid, cfg_pending;
  logic [DW-1:0] out_data [0:SZ-1];
  logic [SN-1:0] active_cfg;
  logic [15:0]   vec_count;
  logic          w_in_ready, w_out_valid, w_cfg_pending;
  logic [DW-1:0] w_out_data [0:SZ-1];
  logic [SN-1:0] w_active_cfg;
  logic [3:0]    w_vec_count;

  int errors = 0;
  int checks = 0;

  vec_t          exp_q[$];
  logic [SN-1:0] m_active, m_shadow;
  int unsigned   m_delivered, m_accepted;
  bit            m_ready_ok;

  always #5 clk = ~clk;

  benes_stage_pipe dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bits(cfg_bits),
    .cfg_commit(cfg_commit), .bypass(bypass), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .active_cfg(active_cfg),
    .cfg_pending(cfg_pending), .vec_count(vec_count)
  );

  // Narrow counter copy, to see the wrap to zero within a short run.
  benes_stage_pipe #(.CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bits(cfg_bits),
    .cfg_commit(cfg_commit), .bypass(bypass), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_data(in_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .active_cfg(w_active_cfg),
    .cfg_pending(w_cfg_pending), .vec_count(w_vec_count)
  );

  function automatic logic [DW*SZ-1:0] pack(input vec_t v);
    logic [DW*SZ-1:0] p;
    for (int k = 0; k < SZ; k++) p[k*DW +: DW] = v[k];
    return p;
  endfunction

  // Reference routing: pair i swapped when its switch is crossed and not bypassed.
  function automatic vec_t route(input vec_t v, input logic [SN-1:0] a, input logic byp);
    vec_t r;
    for (int i = 0; i < SN; i++) begin
      if (a[i] && !byp) begin
        r[2*i]   = v[2*i+1];
        r[2*i+1] = v[2*i];
      end else begin
        r[2*i]   = v[2*i];
        r[2*i+1] = v[2*i+1];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active    = '0;
    m_shadow    = '0;
    m_delivered = 0;
    m_ready_ok  = 1'b0;
  endtask

  // Check outputs mid-cycle, then advance the model over the coming edge.
  task automatic cycle();
    bit exp_valid, exp_ready, acc, del;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    exp_ready = m_ready_ok && (exp_q.size() < 2);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, exp_ready);
    if (exp_valid) chk("out_data", pack(out_data), pack(exp_q[0]));
    chk("vec_count", vec_count, m_delivered[15:0]);
    chk("vec_count_wrap4", w_vec_count, m_delivered[3:0]);
    chk("active_cfg", active_cfg, m_active);
    chk("cfg_pending", cfg_pending, m_shadow != m_active);
    acc = in_valid && exp_ready;
    del = exp_valid && out_ready;
    if (del) begin
      void'(exp_q.pop_front());
      m_delivered++;
    end
    if (acc) begin
      exp_q.push_back(route(in_data, m_active, bypass));
      m_accepted++;
    end
    if (cfg_commit) m_active = cfg_valid ? cfg_bits : m_shadow;
    if (cfg_valid) m_shadow = cfg_bits;
    m_ready_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_active_cfg", active_cfg, '0);
    chk("rst_cfg_pending", cfg_pending, 1'b0);
    chk("rst_vec_count", vec_count, '0);
    chk("rst_out_data", pack(out_data), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_vec_idx();
    for (int k = 0; k < SZ; k++) in_data[k] = k[DW-1:0];
  endtask

  task automatic set_vec_rand();
    for (int k = 0; k < SZ; k++) in_data[k] = DW'($urandom_range(0, 15));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned target, budget;
    cfg_valid = 0; cfg_commit = 0; bypass = 0; in_valid = 0; out_ready = 0;
    cfg_bits = '0;
    set_vec_idx();
    m_accepted = 0;
    model_reset();

    // Reset and identity routing.
    do_reset();
    out_ready = 1;
    cycle();
    set_vec_idx();
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    cycle();

    // Cross all: load, observe pending, commit, then straight and bypassed sends.
    cfg_valid = 1; cfg_bits = '1;
    cycle();
    cfg_valid = 0;
    cycle();
    cfg_commit = 1;
    cycle();
    cfg_commit = 0;
    in_valid = 1;
    cycle();
    bypass = 1;
    cycle();
    bypass = 0; in_valid = 0;
    cycle();

    // Commit timing: A, B (commit in B's cycle), C.
    cfg_valid = 1; cfg_commit = 1; cfg_bits = '0;
    cycle();
    cfg_commit = 0; cfg_bits = '1;
    cycle();
    cfg_valid = 0;
    in_valid = 1; set_vec_rand();
    cycle();
    cfg_commit = 1; set_vec_rand();
    cycle();
    cfg_commit = 0; set_vec_rand();
    cycle();
    // Load and commit together with D; E sees the new pattern.
    cfg_valid = 1; cfg_commit = 1; cfg_bits = 16'h5555; set_vec_rand();
    cycle();
    cfg_valid = 0; cfg_commit = 0; set_vec_rand();
    cycle();
    in_valid = 0;
    cycle();

    // Back-pressure: fill both entries, hold, then drain.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_vec_rand();
      cycle();
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic with random config activity.
    target = m_accepted + 10000;
    budget = 0;
    while (m_accepted < target && budget < 60000) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_commit = ($urandom_range(0, 9) == 0);
      bypass     = ($urandom_range(0, 4) == 0);
      cfg_bits   = SN'($urandom);
      set_vec_rand();
      cycle();
      budget++;
    end
    chk("random_accepted_within_budget", m_accepted >= target, 1'b1);
    in_valid = 0; cfg_valid = 0; cfg_commit = 0; bypass = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) cycle();

    // Reset while FULL with a nonzero active config.
    cfg_valid = 1; cfg_commit = 1; cfg_bits = 16'hA5C3;
    cycle();
    cfg_valid = 0; cfg_commit = 0;
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_vec_rand();
      cycle();
    end
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    set_vec_rand();
    in_valid = 1;
    cycle();
    in_valid = 0;
    for (int i = 0; i < 2; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
